// File: rtl/ipsxb_fft_shim_pkg.sv
// ---------------------------------------------------------------------------
// ipsxb_fft_shim_pkg
// Shared width helpers and the serialiser state type for the FFT pin shim.
// Widths depend on per-instance parameters, so they are exposed as constant
// functions that each module evaluates into its own localparams.
// ---------------------------------------------------------------------------
package ipsxb_fft_shim_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Round a bit width up to a whole number of bytes.
  function automatic int ceil8(input int w);
    return 8 * ((w + 7) / 8);
  endfunction

  function automatic int din_w(input int in_w);
    return ceil8(in_w);
  endfunction

  function automatic int dout_w(input int out_w);
    return ceil8(out_w);
  endfunction

  // Block exponent plus output index, padded to bytes. A multiple-of-8
  // LOG_LEN still needs a whole extra byte for the exponent field.
  function automatic int user_w(input int log_len);
    return 8 * (log_len / 8 + ((log_len % 8 == 0) ? 1 : 2));
  endfunction

  function automatic int ibits(input int in_w);
    return 2 * din_w(in_w);
  endfunction

  function automatic int obits(input int out_w, input int log_len);
    return 2 * dout_w(out_w) + user_w(log_len) + 1;
  endfunction

endpackage

// File: rtl/ipsxb_fft_pin_ser.sv
// ---------------------------------------------------------------------------
// ipsxb_fft_pin_ser
// Output serialiser: captures one FFT output beat and shifts it out MSB-first
// on a single pin, with a frame marker on the first bit of every word.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   s_tvalid_i   beat valid from the FFT core
//   beat_i       {tlast, tuser, tdata} of the beat
//   ser_dout_o   serial data bit
//   ser_frm_o    high on the first bit of each word
//   drop_o       sticky: a beat arrived while a word was still shifting
// ---------------------------------------------------------------------------
module ipsxb_fft_pin_ser
  import ipsxb_fft_shim_pkg::*;
#(
  parameter int OBITS = 57
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_tvalid_i,
  input  logic [OBITS-1:0] beat_i,
  output logic             ser_dout_o,
  output logic             ser_frm_o,
  output logic             drop_o
);

  localparam int OCNT_W = $clog2(OBITS);

  ser_state_e        state_q, state_d;
  logic [OBITS-1:0]  sr_q, sr_d;
  logic [OCNT_W-1:0] cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              last_bit;

  assign last_bit = (cnt_q == OCNT_W'(OBITS - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments only; blocking ones
  // here would make the result depend on simulator process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a hold default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (s_tvalid_i) begin
          sr_d    = beat_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          // A beat on the final bit reloads directly: no idle gap.
          if (s_tvalid_i) sr_d = beat_i;
          else            state_d = IDLE;
        end else begin
          sr_d  = sr_q << 1;
          cnt_d = cnt_q + OCNT_W'(1);
          if (s_tvalid_i) drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pin is quiet while idle.
  always_comb begin
    ser_dout_o = 1'b0;
    ser_frm_o  = 1'b0;
    if (state_q == SHIFT) begin
      ser_dout_o = sr_q[OBITS-1];
      ser_frm_o  = (cnt_q == '0);
    end
  end

  assign drop_o = drop_q;

endmodule

// File: rtl/ipsxb_fft_pin_shim.sv
// ---------------------------------------------------------------------------
// ipsxb_fft_pin_shim
// Pin-level wrapper letting an FFT core be implemented with few pins.
// Input side : serial pin -> IBITS sample word -> one-entry holding register
//              -> AXI4-Stream master with generated frame tlast.
// Output side: every FFT output beat is serialised MSB-first onto a pin.
// Ports:
//   i_aclk, i_areset          clock, synchronous active-high reset
//   i_ser_vld, i_ser_din      serial input bit strobe and data (MSB first)
//   o_m_tvalid/tdata/tlast    sample stream to the FFT core ({im, re})
//   i_m_tready                FFT core ready
//   i_s_tvalid/tdata/tuser/tlast  FFT core output beat
//   o_ser_dout, o_ser_frm     serial output bit and first-bit marker
//   o_ovf                     sticky: completed input word was lost
//   o_drop                    sticky: output beat was lost
// ---------------------------------------------------------------------------
module ipsxb_fft_pin_shim
  import ipsxb_fft_shim_pkg::*;
#(
  parameter  int IN_W    = 11,
  parameter  int OUT_W   = 11,
  parameter  int LOG_LEN = 13,
  localparam int DIN_W   = din_w(IN_W),
  localparam int DOUT_W  = dout_w(OUT_W),
  localparam int USER_W  = user_w(LOG_LEN),
  localparam int IBITS   = ibits(IN_W),
  localparam int OBITS   = obits(OUT_W, LOG_LEN)
) (
  input  logic                i_aclk,
  input  logic                i_areset,
  input  logic                i_ser_vld,
  input  logic                i_ser_din,
  output logic                o_m_tvalid,
  output logic [IBITS-1:0]    o_m_tdata,
  output logic                o_m_tlast,
  input  logic                i_m_tready,
  input  logic                i_s_tvalid,
  input  logic [2*DOUT_W-1:0] i_s_tdata,
  input  logic [USER_W-1:0]   i_s_tuser,
  input  logic                i_s_tlast,
  output logic                o_ser_dout,
  output logic                o_ser_frm,
  output logic                o_ovf,
  output logic                o_drop
);

  localparam int CNT_W = $clog2(IBITS);

  // Assembly register holds only the bits received so far; the final bit
  // completes the word combinationally, so IBITS-1 flops suffice.
  logic [IBITS-2:0]   asm_q, asm_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [IBITS-1:0]   hold_q, hold_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [LOG_LEN-1:0] fcnt_q, fcnt_d;
  logic               ovf_q, ovf_d;

  logic [IBITS-1:0]   word_w;
  logic               word_done;
  logic               hs;
  logic               load;

  assign word_w    = {asm_q, i_ser_din};
  assign word_done = i_ser_vld && (bcnt_q == CNT_W'(IBITS - 1));
  assign hs        = vld_q && i_m_tready;
  // Entry accepts a word when empty or emptying in the same cycle.
  assign load      = word_done && (!vld_q || hs);

  always_comb begin
    asm_d  = asm_q;
    bcnt_d = bcnt_q;
    hold_d = hold_q;
    vld_d  = vld_q;
    last_d = last_q;
    fcnt_d = fcnt_q;
    ovf_d  = ovf_q;

    if (i_ser_vld) begin
      asm_d  = word_w[IBITS-2:0];
      bcnt_d = word_done ? '0 : bcnt_q + CNT_W'(1);
    end

    if (hs) begin
      vld_d  = 1'b0;
      fcnt_d = fcnt_q + LOG_LEN'(1);
    end

    if (load) begin
      hold_d = word_w;
      vld_d  = 1'b1;
      // Frame position includes this cycle's handshake.
      last_d = (fcnt_d == '1);
    end else if (word_done) begin
      ovf_d = 1'b1;
    end
  end

  // NOTE: the holding register is reset along with the control state so
  // o_m_tdata reads 0 after reset rather than a stale sample.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      asm_q  <= '0;
      bcnt_q <= '0;
      hold_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      bcnt_q <= bcnt_d;
      hold_q <= hold_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_m_tvalid = vld_q;
  assign o_m_tdata  = hold_q;
  assign o_m_tlast  = last_q;
  assign o_ovf      = ovf_q;

  ipsxb_fft_pin_ser #(
    .OBITS (OBITS)
  ) u_ser (
    .clk_i      (i_aclk),
    .rst_i      (i_areset),
    .s_tvalid_i (i_s_tvalid),
    .beat_i     ({i_s_tlast, i_s_tuser, i_s_tdata}),
    .ser_dout_o (o_ser_dout),
    .ser_frm_o  (o_ser_frm),
    .drop_o     (o_drop)
  );

endmodule

// File: doc/ipsxb_fft_pin_shim.md
Name: ipsxb_fft_pin_shim

Overview:
- Parametrised pin-level shim that lets an FFT core be placed and routed on its own with a small pin count.
- Input side: a 1-bit serial pin is deserialised into full AXI4-Stream sample words, with a holding register, honoured tready backpressure and a generated frame tlast.
- Output side: every FFT output beat ({tlast, tuser, tdata}) is captured and serialised MSB-first onto a pin, so all core output bits stay observable and cannot be optimised away.
- Sticky overflow and drop flags report lost words.

Parameters:
- IN_W, 11: input sample component width in bits.
- OUT_W, 11: output sample component width in bits.
- LOG_LEN, 13: log2 of FFT frame length, range 3..16.
- Derived localparam DIN_W = 8*ceil(IN_W/8).
- Derived localparam DOUT_W = 8*ceil(OUT_W/8).
- Derived localparam USER_W = 8*(LOG_LEN/8 + (LOG_LEN%8==0 ? 1 : 2)).
- Derived localparam IBITS = 2*DIN_W.
- Derived localparam OBITS = 2*DOUT_W + USER_W + 1.

Ports:
- i_aclk  in  1  single clock.
- i_areset  in  1  synchronous, active-high reset.
- i_ser_vld  in  1  serial input bit valid.
- i_ser_din  in  1  serial input bit, MSB first.
- o_m_tvalid  out  1  sample word valid to the FFT core.
- o_m_tdata  out  IBITS  sample word {im, re}.
- o_m_tlast  out  1  last sample of the frame.
- i_m_tready  in  1  FFT core ready.
- i_s_tvalid  in  1  FFT core output valid.
- i_s_tdata  in  2*DOUT_W  FFT core output data.
- i_s_tuser  in  USER_W  FFT core block exponent and index.
- i_s_tlast  in  1  FFT core output last.
- o_ser_dout  out  1  serial output bit, MSB first.
- o_ser_frm  out  1  high during the first bit of each output word.
- o_ovf  out  1  sticky flag: input word lost.
- o_drop  out  1  sticky flag: output beat lost.

Behaviour:
- Reset: on i_areset high at a clock edge, every output and all internal state go to 0 on the next cycle: counters, shift registers, holding register, FSM = IDLE. This applies equally mid-word or mid-frame. Partial words are discarded.
- Input deserialiser:
  - Keep an assembly shift register and a bit counter running 0..IBITS-1.
  - On each i_ser_vld: shift left with i_ser_din entering at the LSB, then increment the counter.
  - When the counter reaches IBITS-1 and i_ser_vld is high, the word is complete and the counter wraps to 0.
  - No i_ser_vld means the register and counter hold.
- Holding register, one entry:
  - A handshake occurs when o_m_tvalid and i_m_tready are both high; the entry empties that cycle.
  - A completed word loads the holding register if the entry is empty, or if it empties in the same cycle. o_m_tvalid then rises the next cycle.
  - Latency is 1 cycle from the edge carrying the last bit to o_m_tvalid.
  - If the entry is full and not handshaking when a word completes, the word is dropped and o_ovf is set. o_ovf clears only on reset.
  - While o_m_tvalid is high, o_m_tdata and o_m_tlast are stable until the handshake.
- Frame counter:
  - LOG_LEN bits wide; increments on each handshake and wraps from 2^LOG_LEN-1 to 0.
  - o_m_tlast is computed when the word loads into the holding register: 1 when the counter equals 2^LOG_LEN-1, counting any handshake in that same cycle.
- Output serialiser FSM, states IDLE and SHIFT:
  - IDLE: if i_s_tvalid, capture {i_s_tlast, i_s_tuser, i_s_tdata} into the OBITS shift register, clear the bit counter and go to SHIFT.
  - SHIFT: drive o_ser_dout with the shift register MSB and shift left each cycle. o_ser_frm = 1 only while the bit counter is 0.
  - On the last bit (counter = OBITS-1): with i_s_tvalid high, capture the new beat and stay in SHIFT, giving a gap-free stream. Otherwise return to IDLE.
  - i_s_tvalid high in SHIFT on any other bit: the beat is lost and o_drop is set (sticky until reset).
  - In IDLE, o_ser_dout = 0 and o_ser_frm = 0.
  - Latency is 1 cycle from capture to the first bit appearing on o_ser_dout.

Decomposition:
- Package ipsxb_fft_shim_pkg holds:
  - a ceil8 function;
  - the derived-width helpers DIN_W, DOUT_W, USER_W, IBITS, OBITS;
  - the FSM state enum {IDLE, SHIFT}.
- Sub-module ipsxb_fft_pin_ser contains the output serialiser FSM and the drop flag. The top level holds the deserialiser, the holding register and the frame counter.

Test Plan:
- Default parameters: shift in 32 bits of 0x12345678 with i_ser_vld=1 and i_m_tready=1 → o_m_tvalid pulses 1 cycle after the last bit, o_m_tdata=0x12345678, o_m_tlast=0.
- LOG_LEN=3: send 8 words with tready always 1 → o_m_tlast=1 on the 8th word only; the 9th word has o_m_tlast=0, showing the counter wrapped.
- Hold i_m_tready=0 and shift in 2 words → first word held stable; second word dropped; o_ovf=1. Then raise tready → the first word handshakes and o_ovf stays 1.
- Single beat i_s_tvalid with tdata=0xA5A5A5A5, tuser=0x00001F, tlast=1 → 57-bit serial stream starting with 1 then 0x00001F, beginning 1 cycle later; o_ser_frm high on the first bit only.
- Back-to-back output beats, the second arriving exactly on bit 56 → no gap and o_drop=0. A third beat arriving on bit 10 → o_drop=1.
- Assert i_areset mid-word (bit 17) and mid-serialisation → all outputs 0 next cycle; a following full 32-bit word deserialises correctly.
